// File: rtl/ucsbece154b_mem_arbiter.sv
// Purpose    : shares one SDRAM-controller read port between the I-cache and D-cache;
//              one requester owns the port for a full BURST_WORDS-word read burst.
// Latency    : request sampled in IDLE -> MemReadRequest/MemReadAddress/Grant 1 cycle later;
//              return strobes are steered combinationally to the owner in the same cycle.
// Backpressure: none toward SDRAM; the losing requester simply holds its request level
//              until the owner's burst and the following DONE cycle have completed.
//
// Ports:
//   Clk, Reset                      clock, asynchronous active-high reset
//   IReadAddress/IReadRequest       I-side burst start address / request level
//   IDataIn/IDataReady              I-side return data (=MemDataIn) / word strobe
//   DReadAddress/DReadRequest       D-side burst start address / request level
//   DDataIn/DDataReady              D-side return data (=MemDataIn) / word strobe
//   MemReadAddress/MemReadRequest   registered address/request to the SDRAM controller
//   MemDataIn/MemDataReady          SDRAM return data / word strobe
//   Grant                           {D,I} one-hot owner, 2'b00 when no burst is active
//
// Build option: define ARB_ROUND_ROBIN_EN to alternate ties between I and D
// (first tie after reset goes to I); otherwise D always wins a tie.
module ucsbece154b_mem_arbiter #(
  parameter int BURST_WORDS = 4,
  parameter int WORD_SIZE   = 32
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic [31:0]          IReadAddress,
  input  logic                 IReadRequest,
  output logic [WORD_SIZE-1:0] IDataIn,
  output logic                 IDataReady,
  input  logic [31:0]          DReadAddress,
  input  logic                 DReadRequest,
  output logic [WORD_SIZE-1:0] DDataIn,
  output logic                 DDataReady,
  output logic [31:0]          MemReadAddress,
  output logic                 MemReadRequest,
  input  logic [WORD_SIZE-1:0] MemDataIn,
  input  logic                 MemDataReady,
  output logic [1:0]           Grant
);

  localparam int              CNT_W    = $clog2(BURST_WORDS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_WORDS - 1);
  localparam logic            OWN_I    = 1'b0;
  localparam logic            OWN_D    = 1'b1;

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t             state_q, state_d;
  logic               owner_q, owner_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               mem_req_q, mem_req_d;
  logic [31:0]        mem_addr_q, mem_addr_d;
  logic [1:0]         grant_q, grant_d;
`ifdef ARB_ROUND_ROBIN_EN
  logic               last_owner_q, last_owner_d;
`endif

  logic any_req;
  logic pick;         // side that wins if IDLE samples a request this cycle
  logic burst_strobe; // a return word that belongs to the active burst
  logic last_word;

  assign any_req      = IReadRequest | DReadRequest;
  assign burst_strobe = (state_q == BUSY) & MemDataReady;
  assign last_word    = burst_strobe & (cnt_q == CNT_LAST);

  always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
    // On a tie, serve the side that did not own the previous burst.
    if (IReadRequest && DReadRequest) pick = ~last_owner_q;
    else                              pick = DReadRequest;
`else
    // Fixed priority: D wins whenever it is requesting.
    pick = DReadRequest;
`endif
  end

  // State register
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q      <= IDLE;
      owner_q      <= OWN_I;
      cnt_q        <= '0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      grant_q      <= 2'b00;
`ifdef ARB_ROUND_ROBIN_EN
      last_owner_q <= OWN_D;
`endif
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      cnt_q        <= cnt_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      grant_q      <= grant_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_owner_q <= last_owner_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req)   state_d = BUSY;
      BUSY:    if (last_word) state_d = DONE;
      DONE:                   state_d = IDLE;  // dead cycle lets the finisher drop its request
      default:                state_d = IDLE;
    endcase
  end

  // Output / datapath logic
  always_comb begin
    owner_d    = owner_q;
    cnt_d      = cnt_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    grant_d    = grant_q;
`ifdef ARB_ROUND_ROBIN_EN
    last_owner_d = last_owner_q;
`endif

    if ((state_q == IDLE) && any_req) begin
      owner_d    = pick;
      mem_addr_d = (pick == OWN_D) ? DReadAddress : IReadAddress;
      mem_req_d  = 1'b1;
      grant_d    = (pick == OWN_D) ? 2'b10 : 2'b01;
    end

    // Strobes outside BUSY never reach here, so the count only moves mid-burst.
    if (burst_strobe) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (last_word) begin
        cnt_d     = '0;
        mem_req_d = 1'b0;
        grant_d   = 2'b00;
`ifdef ARB_ROUND_ROBIN_EN
        last_owner_d = owner_q;
`endif
      end
    end

    IDataReady = burst_strobe & (owner_q == OWN_I);
    DDataReady = burst_strobe & (owner_q == OWN_D);
  end

  assign IDataIn        = MemDataIn;
  assign DDataIn        = MemDataIn;
  assign MemReadAddress = mem_addr_q;
  assign MemReadRequest = mem_req_q;
  assign Grant          = grant_q;

endmodule
